// File: rtl/multi_digit_counter.sv
// Multi-digit up/down counter driven by raw active-low pushbuttons. Each button
// is synchronised and debounced; increase/decrease can optionally auto-repeat.
module multi_digit_counter #(
  parameter int DIGITS          = 4,
  parameter int BASE            = 10,
  parameter int WRAP            = 1,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 0,
  parameter int REPEAT_PERIOD   = 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                button_increase,
  input  logic                button_decrease,
  input  logic                button_clear,
  output logic [4*DIGITS-1:0] digits,
  output logic                wrap_up,
  output logic                wrap_down
);

  localparam int NB       = 3;  // bit 0 increase, bit 1 decrease, bit 2 clear
  localparam int DB_W     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int HW       = $clog2(HOLD_MAX + 1);

  localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0]   DELAY_T  = HW'(REPEAT_DELAY);
  localparam logic [HW-1:0]   PERIOD_T = HW'(REPEAT_PERIOD);
  localparam logic [3:0]      TOP      = 4'(BASE - 1);

  logic [NB-1:0]            raw;
  logic [NB-1:0]            sync1;
  logic [NB-1:0]            sync2;
  logic [NB-1:0]            stable;
  logic [NB-1:0]            armed;
  logic [NB-1:0]            press;
  logic [NB-1:0][DB_W-1:0]  db_cnt;

  logic [1:0]               active;
  logic [1:0]               repeating;
  logic [1:0]               fire;
  logic [1:0][HW-1:0]       hold_cnt;

  logic                     step_inc;
  logic                     step_dec;
  logic                     step_clr;
  logic [4*DIGITS-1:0]      digits_next;
  logic                     up_next;
  logic                     down_next;
  logic                     carry;
  logic                     at_max;
  logic                     at_zero;

  assign raw = {button_clear, button_decrease, button_increase};

  // Synchroniser, debouncer and press detection for all three buttons.
  // NOTE: the synchroniser resets to "pressed" so a button held through reset
  // never arms; a press only counts after a released sample has been seen.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1  <= '0;
      sync2  <= '0;
      stable <= '1;
      armed  <= '0;
      press  <= '0;
      db_cnt <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      armed <= armed | sync2;
      for (int b = 0; b < NB; b++) begin
        press[b] <= 1'b0;
        if (sync2[b] == stable[b]) begin
          db_cnt[b] <= '0;
        end else if (db_cnt[b] == DB_LAST) begin
          stable[b] <= sync2[b];
          db_cnt[b] <= '0;
          press[b]  <= stable[b] & armed[b];
        end else begin
          db_cnt[b] <= db_cnt[b] + DB_W'(1);
        end
      end
    end
  end

  // Auto-repeat: first extra step REPEAT_DELAY cycles after the press step,
  // then one every REPEAT_PERIOD cycles while the stable level stays low.
  always_comb begin
    fire = '0;
    for (int b = 0; b < 2; b++) begin
      fire[b] = active[b] & ~stable[b] &
                (hold_cnt[b] == (repeating[b] ? PERIOD_T : DELAY_T));
    end
  end

  generate
    if (REPEAT_DELAY > 0) begin : g_repeat
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          active    <= '0;
          repeating <= '0;
          hold_cnt  <= '0;
        end else begin
          for (int b = 0; b < 2; b++) begin
            if (press[b]) begin
              active[b]    <= 1'b1;
              repeating[b] <= 1'b0;
              hold_cnt[b]  <= HW'(1);
            end else if (stable[b]) begin
              active[b]    <= 1'b0;
              repeating[b] <= 1'b0;
              hold_cnt[b]  <= '0;
            end else if (fire[b]) begin
              repeating[b] <= 1'b1;
              hold_cnt[b]  <= HW'(1);
            end else if (active[b]) begin
              hold_cnt[b]  <= hold_cnt[b] + HW'(1);
            end
          end
        end
      end
    end else begin : g_no_repeat
      assign active    = '0;
      assign repeating = '0;
      assign hold_cnt  = '0;
    end
  endgenerate

  assign step_inc = press[0] | fire[0];
  assign step_dec = press[1] | fire[1];
  assign step_clr = press[2];

  // Step resolution: clear wins, opposing steps cancel, otherwise ripple.
  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    digits_next = digits;
    up_next     = 1'b0;
    down_next   = 1'b0;
    carry       = 1'b1;
    at_max      = 1'b1;
    at_zero     = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      at_max  = at_max  & (digits[4*i +: 4] == TOP);
      at_zero = at_zero & (digits[4*i +: 4] == 4'd0);
    end
    if (step_clr) begin
      digits_next = '0;
    end else if (step_inc && !step_dec) begin
      for (int i = 0; i < DIGITS; i++) begin
        if (carry) begin
          if (digits[4*i +: 4] == TOP) begin
            digits_next[4*i +: 4] = 4'd0;
          end else begin
            digits_next[4*i +: 4] = digits[4*i +: 4] + 4'd1;
            carry = 1'b0;
          end
        end
      end
      if (at_max) begin
        up_next = 1'b1;
        if (WRAP == 0) digits_next = digits;
      end
    end else if (step_dec && !step_inc) begin
      for (int i = 0; i < DIGITS; i++) begin
        if (carry) begin
          if (digits[4*i +: 4] == 4'd0) begin
            digits_next[4*i +: 4] = TOP;
          end else begin
            digits_next[4*i +: 4] = digits[4*i +: 4] - 4'd1;
            carry = 1'b0;
          end
        end
      end
      if (at_zero) begin
        down_next = 1'b1;
        if (WRAP == 0) digits_next = digits;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      digits    <= '0;
      wrap_up   <= 1'b0;
      wrap_down <= 1'b0;
    end else begin
      digits    <= digits_next;
      wrap_up   <= up_next;
      wrap_down <= down_next;
    end
  end

endmodule

// File: tb/tb_multi_digit_counter.sv
// Self-checking bench: four counter variants share the buttons and are compared
// against directed tables, hand-timed sequences and a value-level model.
module tb_multi_digit_counter;

  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RP = 5;

  typedef enum int {OP_INC, OP_DEC, OP_CLR, OP_BOTH, OP_CLRINC} op_t;

  typedef struct {
    op_t         op;
    int          reps;
    int          n_low;
    logic [7:0]  w;
    logic [7:0]  s;
    logic [11:0] h;
    int          wu_w;
    int          wd_w;
    int          wu_s;
    int          wd_s;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        inc = 1'b1;
  logic        dec = 1'b1;
  logic        clr = 1'b1;
  logic [7:0]  dw, ds, dr;
  logic [11:0] dh;
  logic        wu_w, wd_w, wu_s, wd_s, wu_r, wd_r, wu_h, wd_h;

  int checks = 0;
  int errors = 0;
  int wu_cnt [4] = '{0, 0, 0, 0};
  int wd_cnt [4] = '{0, 0, 0, 0};

  // Model: each instance is a plain integer in 0..limit-1.
  int mval [4] = '{0, 0, 0, 0};
  int mwu  [4] = '{0, 0, 0, 0};
  int mwd  [4] = '{0, 0, 0, 0};
  int mbase[4] = '{10, 10, 10, 16};
  int mdig [4] = '{2, 2, 2, 3};
  int mwrap[4] = '{1, 0, 1, 1};

  always #5 clock = ~clock;

  multi_digit_counter #(.DIGITS(2), .BASE(10), .WRAP(1), .DEBOUNCE_CYCLES(DB)) u_wrap (
    .clock(clock), .reset(reset), .button_increase(inc), .button_decrease(dec),
    .button_clear(clr), .digits(dw), .wrap_up(wu_w), .wrap_down(wd_w));

  multi_digit_counter #(.DIGITS(2), .BASE(10), .WRAP(0), .DEBOUNCE_CYCLES(DB)) u_sat (
    .clock(clock), .reset(reset), .button_increase(inc), .button_decrease(dec),
    .button_clear(clr), .digits(ds), .wrap_up(wu_s), .wrap_down(wd_s));

  multi_digit_counter #(.DIGITS(2), .BASE(10), .WRAP(1), .DEBOUNCE_CYCLES(DB),
                        .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) u_rep (
    .clock(clock), .reset(reset), .button_increase(inc), .button_decrease(dec),
    .button_clear(clr), .digits(dr), .wrap_up(wu_r), .wrap_down(wd_r));

  multi_digit_counter #(.DIGITS(3), .BASE(16), .WRAP(1), .DEBOUNCE_CYCLES(DB)) u_hex (
    .clock(clock), .reset(reset), .button_increase(inc), .button_decrease(dec),
    .button_clear(clr), .digits(dh), .wrap_up(wu_h), .wrap_down(wd_h));

  always @(negedge clock) begin
    if (wu_w) wu_cnt[0]++;
    if (wd_w) wd_cnt[0]++;
    if (wu_s) wu_cnt[1]++;
    if (wd_s) wd_cnt[1]++;
    if (wu_r) wu_cnt[2]++;
    if (wd_r) wd_cnt[2]++;
    if (wu_h) wu_cnt[3]++;
    if (wd_h) wd_cnt[3]++;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] pack(input int v, input int base, input int nd);
    logic [31:0] r;
    int          x;
    r = '0;
    x = v;
    for (int i = 0; i < nd; i++) begin
      r[4*i +: 4] = 4'(x % base);
      x = x / base;
    end
    return r;
  endfunction

  function automatic logic [31:0] dut_digits(input int k);
    case (k)
      0:       return {24'd0, dw};
      1:       return {24'd0, ds};
      2:       return {24'd0, dr};
      default: return {20'd0, dh};
    endcase
  endfunction

  // Number of steps one held press produces on instance k.
  function automatic int steps_for(input int k, input int n_low);
    if (n_low < DB) return 0;
    if (k != 2 || n_low - 1 < RD) return 1;
    return 2 + (n_low - 1 - RD) / RP;
  endfunction

  task automatic model_apply(input op_t op, input int n_low);
    int lim;
    for (int k = 0; k < 4; k++) begin
      lim = mbase[k] ** mdig[k];
      if (n_low >= DB) begin
        case (op)
          OP_CLR, OP_CLRINC: mval[k] = 0;
          OP_INC:
            for (int s = 0; s < steps_for(k, n_low); s++) begin
              if (mval[k] == lim - 1) begin
                mwu[k]++;
                if (mwrap[k] != 0) mval[k] = 0;
              end else mval[k]++;
            end
          OP_DEC:
            for (int s = 0; s < steps_for(k, n_low); s++) begin
              if (mval[k] == 0) begin
                mwd[k]++;
                if (mwrap[k] != 0) mval[k] = lim - 1;
              end else mval[k]--;
            end
          default: ;
        endcase
      end
    end
  endtask

  task automatic compare_all(input string tag);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("%s_digits%0d", tag, k), dut_digits(k), pack(mval[k], mbase[k], mdig[k]));
      check($sformatf("%s_wrapup%0d", tag, k), 32'(wu_cnt[k]), 32'(mwu[k]));
      check($sformatf("%s_wrapdown%0d", tag, k), 32'(wd_cnt[k]), 32'(mwd[k]));
    end
  endtask

  // Hold the op's buttons low for n_low edges, release for n_gap edges.
  task automatic do_op(input op_t op, input int n_low, input int n_gap);
    @(posedge clock);
    #1;
    case (op)
      OP_INC:    inc = 1'b0;
      OP_DEC:    dec = 1'b0;
      OP_CLR:    clr = 1'b0;
      OP_BOTH:   begin inc = 1'b0; dec = 1'b0; end
      OP_CLRINC: begin clr = 1'b0; inc = 1'b0; end
      default:   ;
    endcase
    repeat (n_low) @(posedge clock);
    #1;
    inc = 1'b1;
    dec = 1'b1;
    clr = 1'b1;
    repeat (n_gap) @(posedge clock);
    model_apply(op, n_low);
    @(negedge clock);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [12];
    int   b_wu_w, b_wd_w, b_wu_s, b_wd_s;
    op_t  rop;
    int   r;

    tbl[0]  = '{OP_INC,    8,  6, 8'h09, 8'h09, 12'h009, 0, 0, 0, 0};
    tbl[1]  = '{OP_INC,    1,  6, 8'h10, 8'h10, 12'h00A, 0, 0, 0, 0};
    tbl[2]  = '{OP_INC,    89, 6, 8'h99, 8'h99, 12'h063, 0, 0, 0, 0};
    tbl[3]  = '{OP_INC,    1,  6, 8'h00, 8'h99, 12'h064, 1, 0, 1, 0};
    tbl[4]  = '{OP_DEC,    1,  6, 8'h99, 8'h98, 12'h063, 0, 1, 0, 0};
    tbl[5]  = '{OP_CLR,    1,  6, 8'h00, 8'h00, 12'h000, 0, 0, 0, 0};
    tbl[6]  = '{OP_DEC,    1,  6, 8'h99, 8'h00, 12'hFFF, 0, 1, 0, 1};
    tbl[7]  = '{OP_INC,    1,  3, 8'h99, 8'h00, 12'hFFF, 0, 0, 0, 0};
    tbl[8]  = '{OP_BOTH,   1,  6, 8'h99, 8'h00, 12'hFFF, 0, 0, 0, 0};
    tbl[9]  = '{OP_CLR,    1,  6, 8'h00, 8'h00, 12'h000, 0, 0, 0, 0};
    tbl[10] = '{OP_INC,    42, 6, 8'h42, 8'h42, 12'h02A, 0, 0, 0, 0};
    tbl[11] = '{OP_CLRINC, 1,  6, 8'h00, 8'h00, 12'h000, 0, 0, 0, 0};

    // Reset state
    repeat (2) @(posedge clock);
    @(negedge clock);
    compare_all("reset");
    reset = 1'b1;
    repeat (5) @(posedge clock);

    // Single press latency: step lands after edge DB+3
    @(posedge clock);
    #1 inc = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      @(posedge clock);
      @(negedge clock);
      if (e == 6) check("latency_before", {24'd0, dw}, 32'h00);
      if (e == 7) check("latency_at", {24'd0, dw}, 32'h01);
    end
    inc = 1'b1;
    repeat (20) @(posedge clock);
    model_apply(OP_INC, 10);
    @(negedge clock);
    compare_all("single");

    // Directed table
    for (int t = 0; t < 12; t++) begin
      b_wu_w = wu_cnt[0];
      b_wd_w = wd_cnt[0];
      b_wu_s = wu_cnt[1];
      b_wd_s = wd_cnt[1];
      for (int n = 0; n < tbl[t].reps; n++) do_op(tbl[t].op, tbl[t].n_low, 8);
      check($sformatf("row%0d_wrap", t), {24'd0, dw}, {24'd0, tbl[t].w});
      check($sformatf("row%0d_sat", t), {24'd0, ds}, {24'd0, tbl[t].s});
      check($sformatf("row%0d_rep", t), {24'd0, dr}, {24'd0, tbl[t].w});
      check($sformatf("row%0d_hex", t), {20'd0, dh}, {20'd0, tbl[t].h});
      check($sformatf("row%0d_wu_wrap", t), 32'(wu_cnt[0] - b_wu_w), 32'(tbl[t].wu_w));
      check($sformatf("row%0d_wd_wrap", t), 32'(wd_cnt[0] - b_wd_w), 32'(tbl[t].wd_w));
      check($sformatf("row%0d_wu_sat", t), 32'(wu_cnt[1] - b_wu_s), 32'(tbl[t].wu_s));
      check($sformatf("row%0d_wd_sat", t), 32'(wd_cnt[1] - b_wd_s), 32'(tbl[t].wd_s));
    end

    // Auto-repeat timing: press step at edge 7, repeats at +20, +25, ... +40
    @(posedge clock);
    #1 inc = 1'b0;
    for (int e = 1; e <= 60; e++) begin
      @(posedge clock);
      @(negedge clock);
      if (e == 6)  check("rep_e6",  {24'd0, dr}, 32'h00);
      if (e == 7)  check("rep_e7",  {24'd0, dr}, 32'h01);
      if (e == 26) check("rep_e26", {24'd0, dr}, 32'h01);
      if (e == 27) check("rep_e27", {24'd0, dr}, 32'h02);
      if (e == 31) check("rep_e31", {24'd0, dr}, 32'h02);
      if (e == 32) check("rep_e32", {24'd0, dr}, 32'h03);
      if (e == 46) check("rep_e46", {24'd0, dr}, 32'h05);
      if (e == 47) check("rep_e47", {24'd0, dr}, 32'h06);
      if (e == 44) inc = 1'b1;
    end
    model_apply(OP_INC, 44);
    compare_all("repeat");

    // Randomised presses, glitches and holds against the model
    for (int n = 0; n < 40; n++) begin
      r = int'($urandom_range(0, 9));
      if (r <= 3)      rop = OP_INC;
      else if (r <= 7) rop = OP_DEC;
      else if (r == 8) rop = OP_CLR;
      else             rop = OP_BOTH;
      do_op(rop, int'($urandom_range(1, 48)), int'($urandom_range(6, 12)));
      compare_all($sformatf("rand%0d", n));
    end

    // Async reset mid-hold from 0xFFE, button held through reset release
    do_op(OP_CLR, 6, 8);
    do_op(OP_DEC, 6, 8);
    do_op(OP_DEC, 6, 8);
    compare_all("preload");
    check("hex_ffe", {20'd0, dh}, 32'hFFE);
    @(posedge clock);
    #1 inc = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    #2 reset = 1'b0;
    #1;
    check("async_hex", {20'd0, dh}, 32'h000);
    check("async_wrap", {24'd0, dw}, 32'h00);
    for (int k = 0; k < 4; k++) mval[k] = 0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    repeat (30) @(posedge clock);
    @(negedge clock);
    compare_all("held_through_reset");
    inc = 1'b1;
    repeat (10) @(posedge clock);
    do_op(OP_INC, 6, 8);
    compare_all("repress");
    check("repress_hex", {20'd0, dh}, 32'h001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_digit_counter.md
# multi_digit_counter

Parametrised up/down counter of DIGITS base-BASE digits, driven directly by raw active-low pushbuttons (increase, decrease, clear). It conditions each button internally (2-FF synchroniser and debounce), counts single presses and, optionally, auto-repeats while a button is held. It outputs all digits packed at 4 bits per digit for the seven-segment display path, plus one-cycle boundary flags. It replaces single-digit counters wherever multi-digit entry, saturation or hold-to-repeat is needed.

## Interface
- DIGITS, 4: number of digits, 1..8.
- BASE, 10: radix per digit, 2..16.
- WRAP, 1: 1 = wrap at boundaries, 0 = saturate.
- DEBOUNCE_CYCLES, 16: consecutive stable samples needed to accept a level change, ≥1.
- REPEAT_DELAY, 0: held cycles before auto-repeat starts. 0 disables auto-repeat.
- REPEAT_PERIOD, 1: cycles between auto-repeat steps, ≥1.
- clock  input  1  rising-edge clock, the single clock domain.
- reset  input  1  asynchronous, active-low; zeroes all state.
- button_increase  input  1  raw button, low = pressed.
- button_decrease  input  1  raw button, low = pressed.
- button_clear  input  1  raw button, low = pressed.
- digits  output  4*DIGITS  counter value; digit i occupies [4i+3:4i], digit 0 is least significant.
- wrap_up  output  1  one-cycle pulse when an increment is applied at the maximum value.
- wrap_down  output  1  one-cycle pulse when a decrement is applied at zero.

## Operation
- Per button: a 2-FF synchroniser feeds a debouncer.
  - The debouncer holds a stable level, reset value 1 (released).
  - A counter increments while the synchronised sample differs from the stable level and clears when they match.
  - After DEBOUNCE_CYCLES consecutive differing samples, the stable level flips and the counter clears.
- Press event: stable level goes 1→0. A release produces no event.
- Auto-repeat (REPEAT_DELAY>0), per increase/decrease button:
  - A hold counter starts at the press event.
  - At REPEAT_DELAY held cycles, one extra step is issued; a further step follows every REPEAT_PERIOD cycles after that.
  - The stable level returning to 1 stops repeating immediately.
- Step resolution each cycle, in priority order:
  1. Clear event: all digits go to 0. Pending steps in the same cycle are dropped. No flags.
  2. Increase step and decrease step in the same cycle: they cancel. No change, no flags.
  3. Increase: digit 0 +1.
     - A digit equal to BASE-1 becomes 0 and carries to the next digit, rippling within the cycle.
     - If all digits are BASE-1: WRAP=1 gives all 0 and wrap_up; WRAP=0 holds the value and pulses wrap_up.
  4. Decrease: mirror of increase.
     - A digit equal to 0 becomes BASE-1 and borrows from the next digit.
     - If all digits are 0: WRAP=1 gives all BASE-1 and wrap_down; WRAP=0 holds the value and pulses wrap_down.
- Digit values are always in 0..BASE-1. Unused upper nibble codes are never produced.
- Reset asserted mid-operation:
  - digits=0, flags=0.
  - Debouncer stable levels go to 1 and all counters clear.
  - A button held through reset release must be released and pressed again to count.

## Timing
- Reset values: digits=0, wrap_up=0, wrap_down=0, every internal register in its idle state.
- Press latency: with the raw input low and stable from clock edge 0, digits changes after edge DEBOUNCE_CYCLES+3.
  - 2 edges synchroniser, DEBOUNCE_CYCLES edges debounce, 1 edge registered step.
- wrap_up and wrap_down are registered. They are high in exactly the cycle in which the corresponding step is applied to digits.
- Glitch rejection: a raw pulse or bounce shorter than DEBOUNCE_CYCLES cycles (after synchronisation) produces no event.
- Auto-repeat steps land on digits after edges P+REPEAT_DELAY, P+REPEAT_DELAY+REPEAT_PERIOD, and so on, where P is the press-step edge.
- At most one net step per cycle, so digits changes by at most ±1 per cycle.

## Test plan
Common parameters: DIGITS=2, BASE=10, DEBOUNCE_CYCLES=4, unless stated otherwise.
- Reset and single press: release reset, hold button_increase low 10 cycles, then release -> digits=0x01 first seen after edge 7, no further change, flags 0.
- Carry and wrap: preload to 09 by 9 presses, press increase -> 0x10. Preload 99, press increase -> 0x00 with wrap_up high one cycle. At 00, press decrease -> 0x99 with wrap_down high.
- Saturate, WRAP=0: at 99, press increase -> remains 0x99 with wrap_up pulse. At 00, press decrease -> remains 0x00 with wrap_down pulse.
- Bounce and simultaneity: 3-cycle low glitches on button_increase -> no change. Increase and decrease pressed on the same cycle -> no change. Clear pressed together with increase at 0x42 -> 0x00.
- Auto-repeat, REPEAT_DELAY=20, REPEAT_PERIOD=5: hold increase 40 cycles after the press step -> values 01, then 02 at +20, 03 at +25, continuing to 06 at +40. Release -> stops.
- Async reset mid-hold, with BASE=16, DIGITS=3 and digits=0xFFE: assert reset low between clock edges -> digits=0x000 immediately. Button still held at reset release -> no step until release and re-press.
